// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/RAM interface: RAM status, data word and arbiter state.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_ACC = 2'd1,
    D_ACC = 2'd2
  } arb_state_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: step only while below the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (clear_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;
endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache. Dcache has priority, but
// after MAX_D_STREAK back-to-back dcache grants with icache waiting, icache is
// forced in. RAM controls are combinational from the registered state, so the
// requesters must hold their request until their wait goes low.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int MAX_D_STREAK = 4,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             iREN,
  input  word_t            iaddr,
  output logic             iwait,
  output word_t            iload,
  input  logic             dREN,
  input  logic             dWEN,
  input  word_t            daddr,
  input  word_t            dstore,
  output logic             dwait,
  output word_t            dload,
  output logic             ramREN,
  output logic             ramWEN,
  output word_t            ramaddr,
  output word_t            ramstore,
  input  word_t            ramload,
  input  logic [1:0]       ramstate,
  output logic [CNT_W-1:0] icount,
  output logic [CNT_W-1:0] dcount,
  output logic [CNT_W-1:0] errcount
);
  localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  arb_state_t    state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  ramstate_t     rs;
  logic          d_req, i_done, d_done, err_cyc;

  assign rs    = ramstate_t'(ramstate);
  assign d_req = dREN | dWEN;
  // Read data is passed straight through; wait tells the cache when to take it.
  assign iload = ramload;
  assign dload = ramload;

  // Arbitration, RAM control and completion decode.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    i_done   = 1'b0;
    d_done   = 1'b0;
    err_cyc  = 1'b0;
    case (state_q)
      IDLE: begin
        // Icache only overrides dcache once the streak has hit its limit.
        if (d_req && !(iREN && (streak_q == STREAK_MAX))) state_d = D_ACC;
        else if (iREN)                                     state_d = I_ACC;
      end
      I_ACC: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        err_cyc = (rs == ERROR);
        if (!iREN) begin
          state_d = IDLE;
        end else if (rs == ACCESS) begin
          iwait    = 1'b0;
          i_done   = 1'b1;
          streak_d = '0;
          state_d  = IDLE;
        end
      end
      D_ACC: begin
        ramaddr = daddr;
        if (dWEN) begin
          ramWEN   = 1'b1;
          ramstore = dstore;
        end else begin
          ramREN = 1'b1;
        end
        err_cyc = (rs == ERROR);
        if (!d_req) begin
          state_d = IDLE;
        end else if (rs == ACCESS) begin
          dwait   = 1'b0;
          d_done  = 1'b1;
          state_d = IDLE;
          // Streak only grows while icache is actually being held off.
          if (iREN) streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + SW'(1);
          else      streak_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and streak registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_icnt (
    .clk_i(CLK), .clear_i(RST), .inc_i(i_done), .count_o(icount)
  );
  sat_counter #(.CNT_W(CNT_W)) u_dcnt (
    .clk_i(CLK), .clear_i(RST), .inc_i(d_done), .count_o(dcount)
  );
  sat_counter #(.CNT_W(CNT_W)) u_ecnt (
    .clk_i(CLK), .clear_i(RST), .inc_i(err_cyc), .count_o(errcount)
  );
endmodule
